// File: rtl/qracc_adc_accumulator.sv
// Column-parallel bit-serial accumulator for QR-ACC ADC codes: each accepted bit-plane
// doubles every column's running sum and adds the signed ADC value, with saturation.
module qracc_adc_accumulator #(
  parameter int numCols    = 32,
  parameter int numAdcBits = 4,
  parameter int numCfgBits = 8,
  parameter int accBits    = 16
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [numCfgBits-1:0]         n_input_bits_cfg,
  input  logic                          start_i,
  input  logic                          adc_valid_i,
  input  logic [numCols*numAdcBits-1:0] adc_out_i,
  output logic                          busy_o,
  output logic                          acc_valid_o,
  input  logic                          acc_ready_i,
  output logic [numCols*accBits-1:0]    acc_data_o,
  output logic [numCols-1:0]            sat_o,
  output logic [1:0]                    state_dbg_o
);

  // Result handshake: a result transfers on a rising edge where acc_valid_o and
  // acc_ready_i are both high; until then acc_data_o/sat_o are held stable.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // Two guard bits: doubling needs one, adding the ADC value needs the other.
  localparam int W = accBits + 2;
  localparam logic signed [W-1:0] OFF_W =
    {{(W-numAdcBits){1'b0}}, 1'b1, {(numAdcBits-1){1'b0}}};
  localparam logic signed [W-1:0] MAX_W = {3'b000, {(accBits-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_W = {3'b111, {(accBits-1){1'b0}}};
  localparam logic [accBits-1:0]  ACC_MAX = {1'b0, {(accBits-1){1'b1}}};
  localparam logic [accBits-1:0]  ACC_MIN = {1'b1, {(accBits-1){1'b0}}};

  state_t                       state_q;
  logic                         busy_q;
  logic                         valid_q;
  logic [numCfgBits-1:0]        cfg_q;
  logic [numCfgBits-1:0]        cnt_q;
  logic [numCols*accBits-1:0]   acc_q;
  logic [numCols*accBits-1:0]   acc_d;
  logic [numCols-1:0]           sat_q;
  logic [numCols-1:0]           sat_d;
  logic [numCfgBits-1:0]        last_idx;
  logic                         last_plane;

  // A latched count of zero behaves as a single plane.
  assign last_idx   = (cfg_q == '0) ? '0 : cfg_q - 1'b1;
  assign last_plane = (cnt_q == last_idx);

  for (genvar c = 0; c < numCols; c++) begin : g_col
    logic signed [accBits-1:0] acc_c;
    logic signed [W-1:0]       acc_w;
    logic signed [W-1:0]       code_w;
    logic signed [W-1:0]       sum_w;
    logic                      over;
    logic                      under;

    assign acc_c  = acc_q[c*accBits +: accBits];
    assign acc_w  = {{2{acc_c[accBits-1]}}, acc_c};
    assign code_w = {{(W-numAdcBits){1'b0}}, adc_out_i[c*numAdcBits +: numAdcBits]};
    assign sum_w  = (acc_w <<< 1) + code_w - OFF_W;
    assign over   = (sum_w > MAX_W);
    assign under  = (sum_w < MIN_W);

    assign acc_d[c*accBits +: accBits] = over  ? ACC_MAX :
                                         under ? ACC_MIN : sum_w[accBits-1:0];
    assign sat_d[c] = sat_q[c] | over | under;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      cfg_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sat_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cfg_q   <= n_input_bits_cfg;
            cnt_q   <= '0;
            acc_q   <= '0;
            sat_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (adc_valid_i) begin
            acc_q <= acc_d;
            sat_q <= sat_d;
            if (last_plane) begin
              valid_q <= 1'b1;
              state_q <= S_HOLD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (acc_ready_i) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign acc_valid_o = valid_q;
  assign acc_data_o  = acc_q;
  assign sat_o       = sat_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_qracc_adc_accumulator.sv
// Bench for qracc_adc_accumulator: directed vector table, hand sequences for gaps,
// stalls and mid-pass reset, then randomized passes against an arithmetic model.
module tb_qracc_adc_accumulator;

  localparam int NCOLS = 4;
  localparam int ADCB  = 4;
  localparam int CFGB  = 8;
  localparam int ACCB  = 8;
  localparam int DIN   = NCOLS * ADCB;
  localparam int DW    = NCOLS * ACCB;
  localparam int HALF  = 2 ** (ADCB - 1);
  localparam int AMAX  = 2 ** (ACCB - 1) - 1;
  localparam int AMIN  = -(2 ** (ACCB - 1));

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             nrst;
  logic [CFGB-1:0]  n_input_bits_cfg;
  logic             start_i;
  logic             adc_valid_i;
  logic [DIN-1:0]   adc_out_i;
  logic             busy_o;
  logic             acc_valid_o;
  logic             acc_ready_i;
  logic [DW-1:0]    acc_data_o;
  logic [NCOLS-1:0] sat_o;
  logic [1:0]       state_dbg_o;

  always #5 clk = ~clk;

  qracc_adc_accumulator #(
    .numCols(NCOLS), .numAdcBits(ADCB), .numCfgBits(CFGB), .accBits(ACCB)
  ) dut (
    .clk(clk), .nrst(nrst), .n_input_bits_cfg(n_input_bits_cfg),
    .start_i(start_i), .adc_valid_i(adc_valid_i), .adc_out_i(adc_out_i),
    .busy_o(busy_o), .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i),
    .acc_data_o(acc_data_o), .sat_o(sat_o), .state_dbg_o(state_dbg_o)
  );

  // ---------------- scoreboard state ----------------
  int               chk_cnt  = 0;
  int               pass_cnt = 0;
  logic [DW-1:0]    exp_q[$];
  logic [NCOLS-1:0] exps_q[$];
  logic [ADCB-1:0]  codes[16][NCOLS];
  bit               gap_pat[$];
  logic [DW-1:0]    last_data;
  logic [NCOLS-1:0] last_sat;

  typedef struct {
    int              cfg;
    int              ready_delay;
    logic [ADCB-1:0] c[8];
    logic [ACCB-1:0] exp_d;
    logic            exp_s;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DIN-1:0] pack_codes(input int p);
    logic [DIN-1:0] v;
    for (int c = 0; c < NCOLS; c++) v[c*ADCB +: ADCB] = codes[p][c];
    return v;
  endfunction

  // ---------------- driver: one complete pass ----------------
  task automatic run_pass(input int cfg, input int gap_pct, input int ready_delay,
                          input bit idle_noise);
    int               n;
    int               p;
    int               cyc;
    bit               v;
    int               acc_m[NCOLS];
    bit               sat_m[NCOLS];
    logic [DW-1:0]    run_d[16];
    logic [NCOLS-1:0] run_s[16];
    logic [DW-1:0]    exp_d;
    logic [NCOLS-1:0] exp_s;

    // Reference: plain signed arithmetic with clamp, MSB plane first.
    n = (cfg == 0) ? 1 : cfg;
    for (int c = 0; c < NCOLS; c++) begin
      acc_m[c] = 0;
      sat_m[c] = 1'b0;
    end
    for (int q = 0; q < n; q++) begin
      for (int c = 0; c < NCOLS; c++) begin
        acc_m[c] = 2 * acc_m[c] + int'(codes[q][c]) - HALF;
        if (acc_m[c] > AMAX) begin acc_m[c] = AMAX; sat_m[c] = 1'b1; end
        if (acc_m[c] < AMIN) begin acc_m[c] = AMIN; sat_m[c] = 1'b1; end
        run_d[q][c*ACCB +: ACCB] = acc_m[c][ACCB-1:0];
        run_s[q][c] = sat_m[c];
      end
    end
    exp_q.push_back(run_d[n-1]);
    exps_q.push_back(run_s[n-1]);

    n_input_bits_cfg = CFGB'(cfg);
    start_i     = 1'b1;
    adc_valid_i = 1'b0;
    tick();
    start_i = 1'b0;
    check("start_busy", busy_o, 1);
    check("start_clear_data", acc_data_o, 0);
    check("start_clear_sat", sat_o, 0);
    check("start_valid_low", acc_valid_o, 0);

    p   = 0;
    cyc = 0;
    while (p < n && cyc < 100) begin
      if (gap_pat.size() > 0) v = gap_pat.pop_front();
      else v = ($urandom_range(99) >= gap_pct);
      adc_valid_i      = v;
      adc_out_i        = v ? pack_codes(p) : DIN'($urandom);
      n_input_bits_cfg = CFGB'($urandom);
      start_i          = 1'($urandom_range(1));
      tick();
      cyc++;
      if (v) begin
        check("plane_data", acc_data_o, run_d[p]);
        check("plane_sat", sat_o, run_s[p]);
        p++;
      end
      check("valid_timing", acc_valid_o, (p == n));
    end
    if (p < n) check("plane_timeout", p, n);
    adc_valid_i = 1'b0;
    start_i     = 1'b0;

    for (int d = 0; d < ready_delay; d++) begin
      acc_ready_i = 1'b0;
      adc_valid_i = 1'($urandom_range(1));
      adc_out_i   = DIN'($urandom);
      start_i     = 1'($urandom_range(1));
      tick();
      check("hold_valid", acc_valid_o, 1);
      check("hold_data", acc_data_o, run_d[n-1]);
      check("hold_sat", sat_o, run_s[n-1]);
    end

    adc_valid_i = 1'b0;
    start_i     = 1'b0;
    acc_ready_i = 1'b1;
    exp_d = exp_q.pop_front();
    exp_s = exps_q.pop_front();
    check("sb_valid", acc_valid_o, 1);
    check("sb_data", acc_data_o, exp_d);
    check("sb_sat", sat_o, exp_s);
    last_data = acc_data_o;
    last_sat  = sat_o;
    tick();
    acc_ready_i = 1'b0;
    check("post_valid_low", acc_valid_o, 0);
    check("post_busy_low", busy_o, 0);
    check("idle_retain", acc_data_o, exp_d);

    if (idle_noise) begin
      adc_valid_i = 1'b1;
      adc_out_i   = DIN'($urandom);
      tick();
      adc_valid_i = 1'b0;
      check("idle_ignore_valid", acc_data_o, exp_d);
      check("idle_busy", busy_o, 0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    nrst             = 1'b0;
    n_input_bits_cfg = '0;
    start_i          = 1'b0;
    adc_valid_i      = 1'b0;
    adc_out_i        = '0;
    acc_ready_i      = 1'b0;

    tbl[0] = '{cfg: 4, ready_delay: 1, c: '{9, 8, 10, 7, 0, 0, 0, 0}, exp_d: 8'd11,  exp_s: 1'b0};
    tbl[1] = '{cfg: 8, ready_delay: 0, c: '{15, 15, 15, 15, 15, 15, 15, 15}, exp_d: 8'h7F, exp_s: 1'b1};
    tbl[2] = '{cfg: 8, ready_delay: 2, c: '{0, 0, 0, 0, 0, 0, 0, 0}, exp_d: 8'h80, exp_s: 1'b1};
    tbl[3] = '{cfg: 0, ready_delay: 1, c: '{6, 0, 0, 0, 0, 0, 0, 0}, exp_d: 8'hFE,  exp_s: 1'b0};
    tbl[4] = '{cfg: 1, ready_delay: 0, c: '{12, 0, 0, 0, 0, 0, 0, 0}, exp_d: 8'd4,  exp_s: 1'b0};
    tbl[5] = '{cfg: 2, ready_delay: 5, c: '{8, 8, 0, 0, 0, 0, 0, 0}, exp_d: 8'd0,   exp_s: 1'b0};

    // Reset state
    tick();
    tick();
    check("rst_busy", busy_o, 0);
    check("rst_valid", acc_valid_o, 0);
    check("rst_data", acc_data_o, 0);
    check("rst_sat", sat_o, 0);
    nrst = 1'b1;

    // Directed table; consecutive passes start in the first IDLE cycle after a handshake
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < 8; p++)
        for (int c = 0; c < NCOLS; c++) codes[p][c] = tbl[i].c[p];
      run_pass(tbl[i].cfg, 0, tbl[i].ready_delay, 1'b0);
      check($sformatf("tbl%0d_col0", i), last_data[ACCB-1:0], tbl[i].exp_d);
      check($sformatf("tbl%0d_sat0", i), last_sat[0], tbl[i].exp_s);
    end

    // Gapped valid: only accepted planes count
    for (int c = 0; c < NCOLS; c++) begin
      codes[0][c] = 4'd8;
      codes[1][c] = 4'd8;
      codes[2][c] = 4'd8;
    end
    gap_pat = '{1, 0, 0, 1, 0, 1};
    run_pass(3, 0, 5, 1'b1);
    check("gap_result", last_data, 0);

    // Asynchronous reset in the middle of a 4-plane pass
    n_input_bits_cfg = 8'd4;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int p = 0; p < 2; p++) begin
      adc_valid_i = 1'b1;
      adc_out_i   = {NCOLS{4'd15}};
      tick();
    end
    adc_valid_i = 1'b0;
    check("pre_rst_partial", acc_data_o, {NCOLS{8'd21}});
    #3;
    nrst = 1'b0;
    #1;
    check("async_rst_busy", busy_o, 0);
    check("async_rst_valid", acc_valid_o, 0);
    check("async_rst_data", acc_data_o, 0);
    check("async_rst_sat", sat_o, 0);
    tick();
    tick();
    check("rst_held_valid", acc_valid_o, 0);
    nrst = 1'b1;
    for (int c = 0; c < NCOLS; c++) codes[0][c] = 4'd12;
    run_pass(1, 0, 0, 1'b1);
    check("post_rst_result", last_data, {NCOLS{8'd4}});

    // Randomized passes
    for (int r = 0; r < 30; r++) begin
      for (int p = 0; p < 16; p++)
        for (int c = 0; c < NCOLS; c++) codes[p][c] = ADCB'($urandom);
      run_pass($urandom_range(0, 7), 30, $urandom_range(0, 3), 1'($urandom_range(1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
